// File: rtl/dds_stream_out_pkg.sv
// dds_stream_out_pkg: shared constants and saturation helper for the DDS output stage
package dds_stream_out_pkg;
  localparam int DDS_SIG_WIDTH = 16;
  localparam int SAT_W = 64;
  localparam int CTRL_RST_BIT = 0;
  localparam int CTRL_STRT_BIT = 1;
  localparam int STAT_OVF_BIT = 0;
  localparam int STAT_LEVEL_LSB = 8;
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] v, input int ow);
    logic signed [SAT_W-1:0] hi;
    hi = SAT_W'((64'd1 << (ow - 1)) - 64'd1);
    return v > hi ? hi : v < ~hi ? ~hi : v;
  endfunction
endpackage

// File: rtl/dds_stream_out_sync_fifo.sv
// dds_stream_out_sync_fifo: show-ahead FIFO with wrap-bit pointers
module dds_stream_out_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  assign wr = push && (!full || pop);
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (!a_rst_n || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/dds_stream_out.sv
// dds_stream_out: captures DDS samples on the strobe edge, applies saturating gain and streams them over AXI4-Stream
module dds_stream_out
  import dds_stream_out_pkg::*;
#(
  parameter int SIG_WIDTH = DDS_SIG_WIDTH,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic                        i_sample_en,
  input  logic signed [SIG_WIDTH-1:0] i_dds_signal,
  input  logic                        i_enable,
  input  logic                        i_flush,
  input  logic [3:0]                  i_shift,
  input  logic [15:0]                 i_frame_len,
  input  logic                        i_clr_ovf,
  output logic [OUT_WIDTH-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [$clog2(DEPTH):0]      o_fifo_level,
  output logic                        o_overflow
);
  localparam int S1_W = SIG_WIDTH + 15;
  logic en_q, s1_v, cap, push, pop, drop, full, empty;
  logic signed [S1_W-1:0] s1_d;
  logic [OUT_WIDTH-1:0] s2_d;
  logic [15:0] cnt;
  assign cap = i_sample_en && !en_q && i_enable && !i_flush;
  assign s2_d = OUT_WIDTH'(sat_shift(SAT_W'(s1_d), OUT_WIDTH));
  assign push = s1_v && !i_flush;
  assign m_axis_tvalid = !empty;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign drop = push && full && !pop;
  assign m_axis_tlast = m_axis_tvalid && (i_frame_len != '0) && (cnt >= i_frame_len - 16'd1);
  always_ff @(posedge clk) begin
    if (!a_rst_n) begin
      en_q <= 1'b0;
      s1_v <= 1'b0;
      s1_d <= '0;
      cnt <= '0;
      o_overflow <= 1'b0;
    end else begin
      en_q <= i_sample_en;
      s1_v <= cap;
      if (cap) s1_d <= S1_W'(i_dds_signal) <<< i_shift;
      cnt <= i_flush ? '0 : pop ? (m_axis_tlast ? '0 : cnt + 16'd1) : cnt;
      o_overflow <= drop || (o_overflow && !i_clr_ovf);
    end
  end
  dds_stream_out_sync_fifo #(.DATA_W(OUT_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .a_rst_n(a_rst_n),
    .flush(i_flush),
    .push(push),
    .pop(pop),
    .din(s2_d),
    .dout(m_axis_tdata),
    .full(full),
    .empty(empty),
    .level(o_fifo_level)
  );
endmodule

// File: tb/tb_dds_stream_out.sv
// tb_dds_stream_out: directed scoreboard bench for the DDS output stage
module tb_dds_stream_out;
  localparam int DEPTH = 16;
  typedef struct {logic [15:0] d; logic l;} ent_t;
  logic clk = 1'b0, a_rst_n = 1'b0, i_sample_en = 1'b0, i_enable = 1'b0, i_flush = 1'b0;
  logic i_clr_ovf = 1'b0, m_axis_tready = 1'b0;
  logic [15:0] i_dds_signal = '0, i_frame_len = '0;
  logic [3:0] i_shift = '0;
  logic [15:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, o_overflow;
  logic [4:0] o_fifo_level;
  ent_t exp_q[$];
  ent_t e;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dds_stream_out dut (
    .clk(clk),
    .a_rst_n(a_rst_n),
    .i_sample_en(i_sample_en),
    .i_dds_signal(i_dds_signal),
    .i_enable(i_enable),
    .i_flush(i_flush),
    .i_shift(i_shift),
    .i_frame_len(i_frame_len),
    .i_clr_ovf(i_clr_ovf),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .o_fifo_level(o_fifo_level),
    .o_overflow(o_overflow)
  );
  function automatic logic [15:0] model(input logic [15:0] s, input logic [3:0] sh);
    longint v;
    v = longint'($signed(s)) <<< sh;
    v = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    return 16'(v);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic sb(input logic [15:0] d, input logic l);
    exp_q.push_back('{d, l});
  endtask
  task automatic step();
    if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_axis_tdata), 32'(e.d));
        chk("beat_last", 32'(m_axis_tlast), 32'(e.l));
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input logic [15:0] s, input logic keep, input logic last);
    i_dds_signal = s;
    i_sample_en = 1'b1;
    step();
    i_sample_en = 1'b0;
    step();
    if (keep) sb(model(s, i_shift), last);
  endtask
  initial begin
    step();
    step();
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_level", 32'(o_fifo_level), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    a_rst_n = 1'b1;
    m_axis_tready = 1'b1;
    step();
    i_enable = 1'b1;
    i_dds_signal = 16'h1234;
    i_sample_en = 1'b1;
    chk("t1_n_valid", 32'(m_axis_tvalid), 0);
    step();
    i_sample_en = 1'b0;
    chk("t1_n1_valid", 32'(m_axis_tvalid), 0);
    step();
    chk("t1_n2_valid", 32'(m_axis_tvalid), 1);
    chk("t1_n2_data", 32'(m_axis_tdata), 32'h1234);
    sb(16'h1234, 1'b0);
    step();
    chk("t1_after_valid", 32'(m_axis_tvalid), 0);
    chk("t1_after_level", 32'(o_fifo_level), 0);
    i_enable = 1'b0;
    strobe(16'h5555, 1'b0, 1'b0);
    step();
    chk("disabled_level", 32'(o_fifo_level), 0);
    i_enable = 1'b1;
    i_shift = 4'd1;
    strobe(16'h4000, 1'b0, 1'b0);
    sb(16'h7FFF, 1'b0);
    i_shift = 4'd2;
    strobe(16'hC000, 1'b0, 1'b0);
    sb(16'h8000, 1'b0);
    i_shift = 4'd4;
    strobe(16'hFFFF, 1'b0, 1'b0);
    sb(16'hFFF0, 1'b0);
    repeat (4) step();
    chk("t2_sb_empty", 32'(exp_q.size()), 0);
    i_shift = 4'd0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) strobe(16'h0100 + 16'(i), i < DEPTH, 1'b0);
    step();
    chk("t3_level_full", 32'(o_fifo_level), DEPTH);
    chk("t3_ovf", 32'(o_overflow), 1);
    chk("t3_head_stable", 32'(m_axis_tdata), 32'h0100);
    m_axis_tready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("t3_sb_empty", 32'(exp_q.size()), 0);
    chk("t3_level_empty", 32'(o_fifo_level), 0);
    chk("t3_ovf_kept", 32'(o_overflow), 1);
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(o_overflow), 0);
    m_axis_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) strobe(16'h0200 + 16'(i), 1'b1, 1'b0);
    chk("t4_level_full", 32'(o_fifo_level), DEPTH);
    i_dds_signal = 16'h0300;
    i_sample_en = 1'b1;
    step();
    i_sample_en = 1'b0;
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    sb(16'h0300, 1'b0);
    chk("t4_pushpop_level", 32'(o_fifo_level), DEPTH);
    chk("t4_pushpop_ovf", 32'(o_overflow), 0);
    chk("t4_new_head", 32'(m_axis_tdata), 32'h0201);
    strobe(16'h0400, 1'b0, 1'b0);
    chk("t4_drop_ovf", 32'(o_overflow), 1);
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    chk("t4_clr_only", 32'(o_overflow), 0);
    strobe(16'h0401, 1'b0, 1'b0);
    i_dds_signal = 16'h0402;
    i_sample_en = 1'b1;
    step();
    i_sample_en = 1'b0;
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    chk("t4_set_wins", 32'(o_overflow), 1);
    m_axis_tready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("t4_sb_empty", 32'(exp_q.size()), 0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_keeps_ovf", 32'(o_overflow), 1);
    i_frame_len = 16'd4;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 10; k++) strobe(16'h0500 + 16'(k), 1'b1, k % 4 == 3);
    m_axis_tready = 1'b1;
    repeat (12) step();
    chk("t5_len4_sb_empty", 32'(exp_q.size()), 0);
    i_frame_len = 16'd0;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) strobe(16'h0600 + 16'(k), 1'b1, 1'b0);
    m_axis_tready = 1'b1;
    repeat (5) step();
    i_frame_len = 16'd1;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) strobe(16'h0700 + 16'(k), 1'b1, 1'b1);
    m_axis_tready = 1'b1;
    repeat (5) step();
    chk("t5_sb_empty", 32'(exp_q.size()), 0);
    i_frame_len = 16'd4;
    m_axis_tready = 1'b0;
    i_dds_signal = 16'h0777;
    i_sample_en = 1'b1;
    repeat (5) step();
    i_sample_en = 1'b0;
    repeat (3) step();
    chk("t6_held_level", 32'(o_fifo_level), 1);
    sb(16'h0777, 1'b0);
    m_axis_tready = 1'b1;
    strobe(16'h0778, 1'b1, 1'b0);
    repeat (3) step();
    chk("t6_pre_sb_empty", 32'(exp_q.size()), 0);
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) strobe(16'h0800 + 16'(k), 1'b1, 1'b0);
    chk("t6_queued", 32'(o_fifo_level), 3);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    exp_q.delete();
    chk("t6_flush_valid", 32'(m_axis_tvalid), 0);
    chk("t6_flush_level", 32'(o_fifo_level), 0);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) strobe(16'h0900 + 16'(k), 1'b1, k == 3);
    repeat (3) step();
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
